// File: rtl/inert_pkg.sv
// Shared definitions for the inertial-sensor SPI responder:
// register map, frame bundle and responder FSM states.
package inert_pkg;

  localparam logic [6:0] INT1_CTRL = 7'h0D;
  localparam logic [6:0] WHO_AM_I  = 7'h0F;
  localparam logic [6:0] CTRL1_XL  = 7'h10;
  localparam logic [6:0] CTRL2_G   = 7'h11;
  localparam logic [6:0] OUTX_L_G  = 7'h22;
  localparam logic [6:0] OUTX_H_G  = 7'h23;
  localparam logic [6:0] OUTY_L_G  = 7'h24;
  localparam logic [6:0] OUTY_H_G  = 7'h25;
  localparam logic [6:0] OUTZ_L_G  = 7'h26;
  localparam logic [6:0] OUTZ_H_G  = 7'h27;
  localparam logic [6:0] OUTX_L_XL = 7'h28;
  localparam logic [6:0] OUTX_H_XL = 7'h29;
  localparam logic [6:0] OUTY_L_XL = 7'h2A;
  localparam logic [6:0] OUTY_H_XL = 7'h2B;
  localparam logic [6:0] OUTZ_L_XL = 7'h2C;
  localparam logic [6:0] OUTZ_H_XL = 7'h2D;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_COMMIT
  } state_e;

  typedef struct packed {
    logic       rnw;
    logic [6:0] addr;
    logic [7:0] wdata;
  } frm_t;

endpackage

// File: rtl/spi_resp16.sv
// 16-bit SPI responder shifter: synchronizers, SCLK edge
// detect, bit counter and rx/tx shift registers.
module spi_resp16
  import inert_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ss_n_i,
  input  logic       sclk_i,
  input  logic       mosi_i,
  input  logic [7:0] rdata_i,
  output logic       miso_o,
  output frm_t       frm_o,
  output logic       start_o,
  output logic       stop_o,
  output logic       ok_o
);

  logic [1:0]  ss_q;
  logic        ss_p_q;
  logic [2:0]  sc_q;
  logic [1:0]  mo_q;
  logic        act_q;
  logic        first_q;
  logic        ld_q;
  logic [4:0]  cnt_q;
  logic [15:0] rx_q;
  logic [15:0] tx_q;
  logic [7:0]  cmd_q;

  logic ss_s;
  logic rise;
  logic fall;
  logic start;
  logic stop;

  assign ss_s  = ss_q[1];
  assign rise  = act_q & sc_q[1] & ~sc_q[2];
  assign fall  = act_q & ~sc_q[1] & sc_q[2];
  // Synced SS_n resets low so a frame already in flight
  // at reset release never looks like a fresh fall.
  assign start = ss_p_q & ~ss_s;
  assign stop  = act_q & ss_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_q    <= 2'b00;
      ss_p_q  <= 1'b0;
      sc_q    <= 3'b111;
      mo_q    <= 2'b00;
      act_q   <= 1'b0;
      first_q <= 1'b0;
      ld_q    <= 1'b0;
      cnt_q   <= 5'd0;
      rx_q    <= 16'h0000;
      tx_q    <= 16'h0000;
      cmd_q   <= 8'h00;
    end else begin
      ss_q   <= {ss_q[0], ss_n_i};
      ss_p_q <= ss_s;
      sc_q   <= {sc_q[1:0], sclk_i};
      mo_q   <= {mo_q[0], mosi_i};
      ld_q   <= rise && (cnt_q == 5'd7);
      if (start) begin
        act_q   <= 1'b1;
        first_q <= 1'b1;
        cnt_q   <= 5'd0;
        tx_q    <= 16'h0000;
      end else if (stop) begin
        act_q <= 1'b0;
        tx_q  <= 16'h0000;
      end else begin
        if (rise) begin
          rx_q <= {rx_q[14:0], mo_q[1]};
          if (cnt_q != 5'd17) cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd7) cmd_q <= {rx_q[6:0], mo_q[1]};
        end
        if (fall) first_q <= 1'b0;
        // Pre-shifted by one: the 9th falling edge exposes bit 7.
        if (ld_q) begin
          tx_q <= {1'b0, (cmd_q[7] ? rdata_i : 8'h00), 7'h00};
        end else if (fall && !first_q) begin
          tx_q <= {tx_q[14:0], 1'b0};
        end
      end
    end
  end

  assign miso_o  = tx_q[15] & act_q & ~ss_s;
  assign frm_o   = '{rnw: cmd_q[7], addr: cmd_q[6:0], wdata: rx_q[7:0]};
  assign start_o = start;
  assign stop_o  = stop;
  assign ok_o    = stop && (cnt_q == 5'd16);

endmodule

// File: rtl/inert_spi_resp.sv
// Inertial-sensor SPI responder: register file, sample
// latch with pending buffer, and new-sample interrupt.
module inert_spi_resp
  import inert_pkg::*;
#(
  parameter logic [7:0] WHO_AM_I_VAL = 8'h6A,
  parameter logic [6:0] INT_CLR_ADDR = 7'h2D
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  output logic        INT,
  input  logic        smpl,
  input  logic [15:0] ptch_rt,
  input  logic [15:0] roll_rt,
  input  logic [15:0] yaw_rt,
  input  logic [15:0] ax,
  input  logic [15:0] ay,
  input  logic [15:0] az
);

  frm_t        frm;
  logic [7:0]  rdata;
  logic        start;
  logic        stop;
  logic        ok;

  state_e      state_q;
  logic [7:0]  int1_q;
  logic [7:0]  xl_q;
  logic [7:0]  g_q;
  logic        int_q;
  logic        int_d;
  logic [15:0] data_q [6];
  logic [15:0] pend_q [6];
  logic        pend_v_q;
  logic [15:0] smp_w [6];

  logic in_frm;
  logic commit;
  logic wr_en;
  logic clr;
  logic direct;
  logic drain;
  logic xfer;

  spi_resp16 u_spi (
    .clk     (clk),
    .rst_n   (rst_n),
    .ss_n_i  (SS_n),
    .sclk_i  (SCLK),
    .mosi_i  (MOSI),
    .rdata_i (rdata),
    .miso_o  (MISO),
    .frm_o   (frm),
    .start_o (start),
    .stop_o  (stop),
    .ok_o    (ok)
  );

  assign smp_w[0] = ptch_rt;
  assign smp_w[1] = roll_rt;
  assign smp_w[2] = yaw_rt;
  assign smp_w[3] = ax;
  assign smp_w[4] = ay;
  assign smp_w[5] = az;

  assign in_frm = (state_q == S_SHIFT);
  assign commit = (state_q == S_COMMIT);
  assign wr_en  = commit & ~frm.rnw;
  assign clr    = commit & frm.rnw & (frm.addr == INT_CLR_ADDR);
  assign direct = smpl & ~in_frm;
  assign drain  = pend_v_q & ~in_frm;
  assign xfer   = direct | drain;
  // A sample landing in the clearing cycle keeps INT set.
  assign int_d  = (xfer & int1_q[1]) | (int_q & ~clr);

  always_comb begin
    rdata = 8'h00;
    unique case (frm.addr)
      WHO_AM_I:  rdata = WHO_AM_I_VAL;
      INT1_CTRL: rdata = int1_q;
      CTRL1_XL:  rdata = xl_q;
      CTRL2_G:   rdata = g_q;
      OUTX_L_G:  rdata = data_q[0][7:0];
      OUTX_H_G:  rdata = data_q[0][15:8];
      OUTY_L_G:  rdata = data_q[1][7:0];
      OUTY_H_G:  rdata = data_q[1][15:8];
      OUTZ_L_G:  rdata = data_q[2][7:0];
      OUTZ_H_G:  rdata = data_q[2][15:8];
      OUTX_L_XL: rdata = data_q[3][7:0];
      OUTX_H_XL: rdata = data_q[3][15:8];
      OUTY_L_XL: rdata = data_q[4][7:0];
      OUTY_H_XL: rdata = data_q[4][15:8];
      OUTZ_L_XL: rdata = data_q[5][7:0];
      OUTZ_H_XL: rdata = data_q[5][15:8];
      default:   rdata = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      int1_q   <= 8'h00;
      xl_q     <= 8'h00;
      g_q      <= 8'h00;
      int_q    <= 1'b0;
      pend_v_q <= 1'b0;
      for (int i = 0; i < 6; i++) begin
        data_q[i] <= 16'h0000;
        pend_q[i] <= 16'h0000;
      end
    end else begin
      int_q <= int_d;
      case (state_q)
        S_IDLE:   if (start) state_q <= S_SHIFT;
        S_SHIFT:  if (stop) state_q <= ok ? S_COMMIT : S_IDLE;
        S_COMMIT: state_q <= S_IDLE;
        default:  state_q <= S_IDLE;
      endcase
      if (wr_en) begin
        unique case (frm.addr)
          INT1_CTRL: int1_q <= frm.wdata;
          CTRL1_XL:  xl_q   <= frm.wdata;
          CTRL2_G:   g_q    <= frm.wdata;
          default:   ;
        endcase
      end
      for (int i = 0; i < 6; i++) begin
        if (direct) data_q[i] <= smp_w[i];
        else if (drain) data_q[i] <= pend_q[i];
        if (smpl && in_frm) pend_q[i] <= smp_w[i];
      end
      if (smpl && in_frm) pend_v_q <= 1'b1;
      else if (xfer) pend_v_q <= 1'b0;
    end
  end

  assign INT = int_q;

endmodule

// File: tb/tb_inert_spi_resp.sv
// Bench for inert_spi_resp: host-side SPI frames against a
// register-map model, directed scenarios plus random traffic.
module tb_inert_spi_resp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  logic        MISO;
  logic        INT;
  logic        smpl;
  logic [15:0] smpv [6];

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  m_int1;
  logic [7:0]  m_xl;
  logic [7:0]  m_g;
  logic [15:0] m_data [6];
  logic        m_int;

  always #5 clk = ~clk;

  inert_spi_resp dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .SS_n    (SS_n),
    .SCLK    (SCLK),
    .MOSI    (MOSI),
    .MISO    (MISO),
    .INT     (INT),
    .smpl    (smpl),
    .ptch_rt (smpv[0]),
    .roll_rt (smpv[1]),
    .yaw_rt  (smpv[2]),
    .ax      (smpv[3]),
    .ay      (smpv[4]),
    .az      (smpv[5])
  );

  function automatic logic [7:0] m_read(input logic [6:0] a);
    int off;
    if (a == 7'h0F) return 8'h6A;
    if (a == 7'h0D) return m_int1;
    if (a == 7'h10) return m_xl;
    if (a == 7'h11) return m_g;
    if (a >= 7'h22 && a <= 7'h2D) begin
      off = int'(a) - 34;
      if (off % 2 == 1) return m_data[off / 2][15:8];
      return m_data[off / 2][7:0];
    end
    return 8'h00;
  endfunction

  task automatic m_reset();
    m_int1 = 8'h00;
    m_xl   = 8'h00;
    m_g    = 8'h00;
    m_int  = 1'b0;
    for (int i = 0; i < 6; i++) m_data[i] = 16'h0000;
  endtask

  task automatic m_sample();
    for (int i = 0; i < 6; i++) m_data[i] = smpv[i];
    if (m_int1[1]) m_int = 1'b1;
  endtask

  task automatic m_commit(input logic [15:0] f);
    if (!f[15]) begin
      if (f[14:8] == 7'h0D) m_int1 = f[7:0];
      if (f[14:8] == 7'h10) m_xl = f[7:0];
      if (f[14:8] == 7'h11) m_g = f[7:0];
    end else if (f[14:8] == 7'h2D) begin
      m_int = 1'b0;
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_smpl();
    smpl = 1'b1;
    wclk(1);
    smpl = 1'b0;
  endtask

  task automatic rand_smp();
    for (int i = 0; i < 6; i++) smpv[i] = 16'($urandom);
  endtask

  task automatic ss_lo();
    SS_n = 1'b0;
    wclk(5);
  endtask

  task automatic ss_hi();
    wclk(3);
    SS_n = 1'b1;
    wclk(8);
  endtask

  task automatic bit_x(input logic b, output logic r);
    SCLK = 1'b0;
    MOSI = b;
    wclk(5);
    r = MISO;
    SCLK = 1'b1;
    wclk(5);
  endtask

  task automatic frame(input logic [15:0] f, input int nb,
                       input int sm_at, output logic [15:0] rx);
    logic r;
    logic b;
    rx = 16'h0000;
    ss_lo();
    for (int i = 0; i < nb; i++) begin
      b = 1'b0;
      if (i < 16) b = f[15-i];
      bit_x(b, r);
      if (i < 16) rx[15-i] = r;
      if (i == sm_at) pulse_smpl();
    end
    ss_hi();
  endtask

  task automatic do_read(input logic [6:0] a, input int sm_at,
                         output logic [15:0] got,
                         output logic [15:0] exp);
    logic [15:0] f;
    f = {1'b1, a, 8'h00};
    exp = {8'h00, m_read(a)};
    frame(f, 16, sm_at, got);
    m_commit(f);
    if (sm_at >= 0) m_sample();
  endtask

  task automatic do_write(input logic [6:0] a, input logic [7:0] d,
                          output logic [15:0] got);
    logic [15:0] f;
    f = {1'b0, a, d};
    frame(f, 16, -1, got);
    m_commit(f);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    SS_n  = 1'b1;
    SCLK  = 1'b1;
    MOSI  = 1'b0;
    smpl  = 1'b0;
    for (int i = 0; i < 6; i++) smpv[i] = 16'h0000;
    m_reset();
    wclk(3);
    n_cmp++;
    if (MISO !== 1'b0) begin
      n_err++;
      $display("FAIL reset_miso got=%b want=0", MISO);
    end
    n_cmp++;
    if (INT !== 1'b0) begin
      n_err++;
      $display("FAIL reset_int got=%b want=0", INT);
    end
    rst_n = 1'b1;
    wclk(3);
  endtask

  task automatic test_who_am_i();
    logic [15:0] got;
    logic [15:0] exp;
    do_read(7'h0F, -1, got, exp);
    n_cmp++;
    if (got !== 16'h006A) begin
      n_err++;
      $display("FAIL who_am_i got=%h want=006a", got);
    end
    n_cmp++;
    if (INT !== 1'b0) begin
      n_err++;
      $display("FAIL who_am_i_int got=%b want=0", INT);
    end
    do_read(7'h0D, -1, got, exp);
    n_cmp++;
    if (got !== 16'h0000) begin
      n_err++;
      $display("FAIL int1_reset got=%h want=0000", got);
    end
  endtask

  task automatic test_int_flow();
    logic [15:0] got;
    logic [15:0] exp;
    do_write(7'h0D, 8'h02, got);
    n_cmp++;
    if (got !== 16'h0000) begin
      n_err++;
      $display("FAIL write_miso got=%h want=0000", got);
    end
    rand_smp();
    smpv[0] = 16'h1234;
    pulse_smpl();
    m_sample();
    wclk(2);
    n_cmp++;
    if (INT !== 1'b1) begin
      n_err++;
      $display("FAIL int_set got=%b want=1", INT);
    end
    do_read(7'h22, -1, got, exp);
    n_cmp++;
    if (got !== 16'h0034) begin
      n_err++;
      $display("FAIL ptch_l got=%h want=0034", got);
    end
    do_read(7'h23, -1, got, exp);
    n_cmp++;
    if (got !== 16'h0012) begin
      n_err++;
      $display("FAIL ptch_h got=%h want=0012", got);
    end
    n_cmp++;
    if (INT !== 1'b1) begin
      n_err++;
      $display("FAIL int_hold got=%b want=1", INT);
    end
    do_read(7'h2D, -1, got, exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL rd_2d got=%h want=%h", got, exp);
    end
    n_cmp++;
    if (INT !== 1'b0) begin
      n_err++;
      $display("FAIL int_clr got=%b want=0", INT);
    end
  endtask

  task automatic test_abort();
    logic [15:0] got;
    logic [15:0] exp;
    frame(16'h1060, 10, -1, got);
    do_read(7'h10, -1, got, exp);
    n_cmp++;
    if (got !== 16'h0000) begin
      n_err++;
      $display("FAIL abort10 got=%h want=0000", got);
    end
    frame(16'h1060, 17, -1, got);
    do_read(7'h10, -1, got, exp);
    n_cmp++;
    if (got !== 16'h0000) begin
      n_err++;
      $display("FAIL abort17 got=%h want=0000", got);
    end
    do_write(7'h10, 8'h60, got);
    do_read(7'h10, -1, got, exp);
    n_cmp++;
    if (got !== 16'h0060) begin
      n_err++;
      $display("FAIL write16 got=%h want=0060", got);
    end
  endtask

  task automatic test_mid_smpl();
    logic [15:0] got;
    logic [15:0] exp;
    logic [7:0]  old_l;
    old_l = m_data[5][7:0];
    rand_smp();
    smpv[5] = 16'hBEEF;
    frame(16'hAC00, 16, 8, got);
    m_commit(16'hAC00);
    m_sample();
    n_cmp++;
    if (got !== {8'h00, old_l}) begin
      n_err++;
      $display("FAIL mid_old got=%h want=%h", got, {8'h00, old_l});
    end
    do_read(7'h2C, -1, got, exp);
    n_cmp++;
    if (got !== 16'h00EF) begin
      n_err++;
      $display("FAIL az_l got=%h want=00ef", got);
    end
    do_read(7'h2D, -1, got, exp);
    n_cmp++;
    if (got !== 16'h00BE) begin
      n_err++;
      $display("FAIL az_h got=%h want=00be", got);
    end
    rand_smp();
    do_read(7'h2D, 4, got, exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL clr_set_rd got=%h want=%h", got, exp);
    end
    n_cmp++;
    if (INT !== 1'b1) begin
      n_err++;
      $display("FAIL clr_set_int got=%b want=1", INT);
    end
  endtask

  task automatic test_random();
    logic [15:0] got;
    logic [15:0] exp;
    logic [6:0]  a;
    logic [6:0]  amap [16];
    int          op;
    amap = '{7'h0D, 7'h0F, 7'h10, 7'h11, 7'h22, 7'h23, 7'h24,
             7'h25, 7'h26, 7'h27, 7'h28, 7'h29, 7'h2A, 7'h2B,
             7'h2C, 7'h2D};
    for (int n = 0; n < 60; n++) begin
      op = int'($urandom_range(0, 4));
      if ($urandom_range(0, 3) == 0) a = 7'($urandom);
      else a = amap[$urandom_range(0, 15)];
      case (op)
        0: begin
          if ($urandom_range(0, 1) == 1) a = amap[$urandom_range(0, 3)];
          do_write(a, 8'($urandom), got);
          n_cmp++;
          if (got !== 16'h0000) begin
            n_err++;
            $display("FAIL rnd_wr[%0d] a=%h got=%h want=0000", n, a, got);
          end
        end
        1, 3: begin
          if (op == 3) rand_smp();
          do_read(a, (op == 3) ? int'($urandom_range(0, 14)) : -1,
                  got, exp);
          n_cmp++;
          if (got !== exp) begin
            n_err++;
            $display("FAIL rnd_rd[%0d] a=%h got=%h want=%h", n, a, got, exp);
          end
        end
        2: begin
          rand_smp();
          pulse_smpl();
          m_sample();
          wclk(2);
        end
        default: begin
          frame({1'b0, a, 8'($urandom)},
                ($urandom_range(0, 1) == 1) ? 17 :
                int'($urandom_range(1, 15)), -1, got);
        end
      endcase
      n_cmp++;
      if (INT !== m_int) begin
        n_err++;
        $display("FAIL rnd_int[%0d] op=%0d got=%b want=%b", n, op, INT, m_int);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] got;
    logic [15:0] exp;
    logic        r;
    logic [15:0] f;
    do_write(7'h0D, 8'h02, got);
    do_write(7'h11, 8'h5A, got);
    rand_smp();
    pulse_smpl();
    m_sample();
    wclk(2);
    n_cmp++;
    if (INT !== 1'b1) begin
      n_err++;
      $display("FAIL pre_rst_int got=%b want=1", INT);
    end
    f = 16'h8F00;
    ss_lo();
    for (int i = 0; i < 12; i++) begin
      bit_x(f[15-i], r);
      if (i == 10) begin
        rst_n = 1'b0;
        wclk(2);
        n_cmp++;
        if (MISO !== 1'b0) begin
          n_err++;
          $display("FAIL rst_mid_miso got=%b want=0", MISO);
        end
        n_cmp++;
        if (INT !== 1'b0) begin
          n_err++;
          $display("FAIL rst_mid_int got=%b want=0", INT);
        end
        rst_n = 1'b1;
        wclk(2);
      end
    end
    ss_hi();
    m_reset();
    do_read(7'h11, -1, got, exp);
    n_cmp++;
    if (got !== 16'h0000) begin
      n_err++;
      $display("FAIL rst_ctrl got=%h want=0000", got);
    end
    do_read(7'h0F, -1, got, exp);
    n_cmp++;
    if (got !== 16'h006A) begin
      n_err++;
      $display("FAIL rst_who got=%h want=006a", got);
    end
    do_read(7'h22, -1, got, exp);
    n_cmp++;
    if (got !== 16'h0000) begin
      n_err++;
      $display("FAIL rst_data got=%h want=0000", got);
    end
  endtask

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog expired cmp=%0d err=%0d", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_who_am_i();
    test_int_flow();
    test_abort();
    test_mid_smpl();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
